// File: rtl/dff_array_checker.sv
// Drive-and-check controller for the 64-lane CC_DFF configuration array.
// Lane L = 2*i + j, i = {INIT, SR_VAL, SR_INV, EN_INV, CLK_INV}, D = j.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous reset, active high
//   start           in   one-cycle run request, ignored while busy
//   q_in[63:0]      in   Q outputs returned by the array
//   dut_clk         out  array clock (registered)
//   dut_en          out  array enable (registered)
//   dut_sr          out  array set/reset (registered)
//   busy            out  run in progress
//   done            out  run finished, held until the next accepted start
//   pass            out  done with no failing compare
//   err_count[7:0]  out  failing compare events, saturating at 255
//   first_fail_lane out  lowest mismatching lane of the first failing compare
//   first_fail_step out  step of the first failing compare (0 for the INIT one)
module dff_array_checker #(
    parameter int NUM_STEPS  = 16,
    parameter int SETTLE     = 2,
    parameter bit CHECK_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] q_in,
    output logic        dut_clk,
    output logic        dut_en,
    output logic        dut_sr,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [5:0]  first_fail_lane,
    output logic [7:0]  first_fail_step
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_IWAIT = 4'd1;
    localparam logic [3:0] S_ICMP  = 4'd2;
    localparam logic [3:0] S_SETUP = 4'd3;
    localparam logic [3:0] S_RISE  = 4'd4;
    localparam logic [3:0] S_WAIT1 = 4'd5;
    localparam logic [3:0] S_CMP1  = 4'd6;
    localparam logic [3:0] S_FALL  = 4'd7;
    localparam logic [3:0] S_WAIT2 = 4'd8;
    localparam logic [3:0] S_CMP2  = 4'd9;
    localparam logic [3:0] S_DONE  = 4'd10;

    localparam logic [7:0]  LAST   = 8'(NUM_STEPS - 1);
    localparam logic [15:0] SET_M1 = 16'(SETTLE - 1);

    // Per-lane configuration bit b of the lane index; b == 5 selects D.
    function automatic logic [63:0] lane_mask(input int b);
        logic [63:0] m;
        logic [4:0]  cf;
        m = '0;
        for (int l = 0; l < 64; l++) begin
            cf = 5'(l >> 1);
            if (b >= 5) begin
                m[l] = 1'(l & 1);
            end else begin
                m[l] = cf[b[2:0]];
            end
        end
        return m;
    endfunction

    localparam logic [63:0] M_CLKINV = lane_mask(0);
    localparam logic [63:0] M_ENINV  = lane_mask(1);
    localparam logic [63:0] M_SRINV  = lane_mask(2);
    localparam logic [63:0] M_SRVAL  = lane_mask(3);
    localparam logic [63:0] M_INIT   = lane_mask(4);
    localparam logic [63:0] M_D      = lane_mask(5);
    localparam logic [63:0] KNOWN_RST = {64{CHECK_INIT}};

    logic [3:0]  r_state;
    logic [15:0] r_wcnt;
    logic [7:0]  r_step;
    logic        r_dut_clk;
    logic        r_dut_en;
    logic        r_dut_sr;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_err;
    logic [5:0]  r_ffl;
    logic [7:0]  r_ffs;
    logic [63:0] r_exp;
    logic [63:0] r_known;

    logic [3:0]  w_state_nx;
    logic [15:0] w_wcnt_nx;
    logic [7:0]  w_step_nx;
    logic        w_clk_nx;
    logic        w_en_nx;
    logic        w_sr_nx;
    logic        w_accept;
    logic        w_cmp;
    logic        w_finish;

    // Sequencer: every state's drive values are visible while in that state,
    // so the outputs are set on the edge that enters the state.
    always_comb begin
        w_state_nx = r_state;
        w_wcnt_nx  = r_wcnt;
        w_step_nx  = r_step;
        w_clk_nx   = r_dut_clk;
        w_en_nx    = r_dut_en;
        w_sr_nx    = r_dut_sr;
        w_accept   = 1'b0;
        w_cmp      = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_step_nx = 8'd0;
                    if (CHECK_INIT) begin
                        w_state_nx = S_IWAIT;
                        w_wcnt_nx  = SET_M1;
                    end else begin
                        w_state_nx = S_SETUP;
                    end
                end
            end
            S_IWAIT: begin
                if (r_wcnt == 16'd0) begin
                    w_state_nx = S_ICMP;
                end else begin
                    w_wcnt_nx = r_wcnt - 16'd1;
                end
            end
            S_ICMP: begin
                w_cmp      = 1'b1;
                w_state_nx = S_SETUP;
            end
            S_SETUP: begin
                w_state_nx = S_RISE;
                w_clk_nx   = 1'b1;
            end
            S_RISE: begin
                w_state_nx = S_WAIT1;
                w_wcnt_nx  = SET_M1;
            end
            S_WAIT1: begin
                if (r_wcnt == 16'd0) begin
                    w_state_nx = S_CMP1;
                end else begin
                    w_wcnt_nx = r_wcnt - 16'd1;
                end
            end
            S_CMP1: begin
                w_cmp      = 1'b1;
                w_state_nx = S_FALL;
                w_clk_nx   = 1'b0;
            end
            S_FALL: begin
                w_state_nx = S_WAIT2;
                w_wcnt_nx  = SET_M1;
            end
            S_WAIT2: begin
                if (r_wcnt == 16'd0) begin
                    w_state_nx = S_CMP2;
                end else begin
                    w_wcnt_nx = r_wcnt - 16'd1;
                end
            end
            S_CMP2: begin
                w_cmp = 1'b1;
                if (r_step == LAST) begin
                    w_state_nx = S_DONE;
                    w_finish   = 1'b1;
                end else begin
                    w_step_nx  = r_step + 8'd1;
                    w_state_nx = S_SETUP;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        // Entering SETUP loads the step's enable/sr pattern with the clock low.
        if (w_state_nx == S_SETUP) begin
            w_en_nx  = w_step_nx[0];
            w_sr_nx  = (w_step_nx[2:1] == 2'b11);
            w_clk_nx = 1'b0;
        end
    end

    logic        w_chg;
    logic        w_rise;
    logic        w_fall;
    logic [63:0] w_sr_act;
    logic [63:0] w_en_act;
    logic [63:0] w_edge;
    logic [63:0] w_load;
    logic [63:0] w_exp_nx;
    logic [63:0] w_known_nx;

    // Golden model, evaluated against the values about to be driven.
    // It only moves when a driven output actually changes, like the array.
    always_comb begin
        w_chg = (w_clk_nx != r_dut_clk) | (w_en_nx != r_dut_en)
              | (w_sr_nx != r_dut_sr);
        w_rise   = ~r_dut_clk & w_clk_nx;
        w_fall   = r_dut_clk & ~w_clk_nx;
        w_sr_act = {64{w_sr_nx}} ^ M_SRINV;
        w_en_act = {64{w_en_nx}} ^ M_ENINV;
        w_edge   = ({64{w_rise}} & ~M_CLKINV) | ({64{w_fall}} & M_CLKINV);
        w_load   = ~w_sr_act & w_edge & w_en_act;
        w_exp_nx = (w_sr_act & M_SRVAL) | (w_load & M_D)
                 | (~w_sr_act & ~w_load & r_exp);
        w_known_nx = r_known | w_sr_act | w_load;
    end

    logic [63:0] w_mism;
    logic        w_any;
    logic [5:0]  w_low;

    always_comb begin
        w_mism = (q_in ^ r_exp) & r_known;
        w_any  = |w_mism;
        w_low  = 6'd0;
        for (int k = 63; k >= 0; k--) begin
            if (w_mism[k]) begin
                w_low = 6'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wcnt    <= 16'd0;
            r_step    <= 8'd0;
            r_dut_clk <= 1'b0;
            r_dut_en  <= 1'b0;
            r_dut_sr  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 8'd0;
            r_ffl     <= 6'd0;
            r_ffs     <= 8'd0;
            r_exp     <= M_INIT;
            r_known   <= KNOWN_RST;
        end else begin
            r_state   <= w_state_nx;
            r_wcnt    <= w_wcnt_nx;
            r_step    <= w_step_nx;
            r_dut_clk <= w_clk_nx;
            r_dut_en  <= w_en_nx;
            r_dut_sr  <= w_sr_nx;
            if (w_chg) begin
                r_exp   <= w_exp_nx;
                r_known <= w_known_nx;
            end
            if (w_accept) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 8'd0;
                r_ffl  <= 6'd0;
                r_ffs  <= 8'd0;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_cmp && w_any) begin
                if (r_err != 8'hFF) begin
                    r_err <= r_err + 8'd1;
                end
                // A zero count means this is the run's first failing compare.
                if (r_err == 8'd0) begin
                    r_ffl <= w_low;
                    r_ffs <= (r_state == S_ICMP) ? 8'd0 : r_step;
                end
            end
        end
    end

    assign dut_clk         = r_dut_clk;
    assign dut_en          = r_dut_en;
    assign dut_sr          = r_dut_sr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_done & (r_err == 8'd0);
    assign err_count       = r_err;
    assign first_fail_lane = r_ffl;
    assign first_fail_step = r_ffs;

endmodule
